serial_sub_ctrl: RTL and testbench
==================================

Name: serial_sub_ctrl

Overview:
- Bit-serial subtractor controller: accepts two WIDTH-bit operands, computes A − B one bit per cycle LSB-first on a single-bit full-subtractor cell, returns difference and final borrow.
- Area-lean alternative to a WIDTH-wide ripple subtractor, for the arithmetic blocks of the design.
- Valid/ready handshake on both the operand side and the result side.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
- clk  in  1  system clock; one clock domain, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  controller can accept operands; high only in IDLE.
- a  in  WIDTH  minuend.
- b  in  WIDTH  subtrahend.
- out_valid  out  1  result valid; high only in DONE.
- out_ready  in  1  consumer accepts result.
- diff  out  WIDTH  difference A − B mod 2^WIDTH.
- borrow  out  1  final borrow; set when A < B unsigned.

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE; shift registers, borrow flop, counter, diff and borrow clear to 0.
  - out_valid=0; in_ready=1 from the first cycle after reset.
- Reset mid-operation aborts the operation with no result emitted.
- States: IDLE, RUN, DONE. Outputs are decoded from registered state only; no combinational input-to-output paths.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: load a, b into shift registers, clear borrow flop and bit counter, go to RUN.
- RUN: each cycle, the cell takes (a_sr[0], b_sr[0], borrow_q) and produces (d, bo).
  - d shifts into diff_sr MSB, with diff_sr shifting right.
  - a_sr and b_sr shift right; borrow_q<=bo; counter increments.
  - When counter==WIDTH−1 on a RUN cycle, go to DONE.
  - in_ready=0; in_valid is ignored, with no queueing.
- DONE:
  - out_valid=1; diff and borrow are stable and held.
  - On out_valid&&out_ready: go to IDLE. in_ready rises the next cycle, so there is no same-cycle result/operand overlap.
- Latency:
  - Accept edge to out_valid=1 is exactly WIDTH+1 cycles.
  - Throughput is one operation per WIDTH+2 cycles minimum, with out_ready held high.
- Cell arithmetic:
  - d = x^y^bin.
  - bo = (~x&y) | (~(x^y)&bin).
- Counter width is max(1,$clog2(WIDTH)). WIDTH=1 goes RUN to DONE after a single RUN cycle.
- Backpressure: with out_ready=0, DONE is held indefinitely and outputs must not change.
- Operands are sampled only at the accept edge; later changes on a/b have no effect.

Optional Feature:
- Macro: SERIAL_SUB_SAT_EN.
- Defined:
  - At the transition to DONE, if the final borrow=1, diff is forced to 0 (unsigned saturating subtract).
  - The borrow output still reports 1.
- Undefined: diff is the wrapped modulo-2^WIDTH result; no extra logic.

Decomposition:
- Shared package serial_arith_pkg:
  - State enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - Localparam for the counter width function.
  - Typedef for the 2-bit state.
- One natural sub-module: sub_bit_cell, a 1-bit full subtractor built from two half-subtractor stages plus an OR of their borrows.
  - Purely combinational; instantiated once.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, out_ready=1 -> out_valid exactly 9 cycles after accept; diff=0x1E, borrow=0.
- a=0x00, b=0x01 -> diff=0xFF, borrow=1; with SERIAL_SUB_SAT_EN -> diff=0x00, borrow=1.
- Backpressure: a=0xFF, b=0xFF, out_ready=0 for 5 cycles after DONE -> out_valid held at 1, diff=0x00, borrow=0 stable; in_ready=0 throughout; in_ready=1 the cycle after the out_ready pulse.
- Operand stability: in_valid held high with new a/b during RUN -> ignored; first result is unchanged and the second operand pair is accepted only after return to IDLE.
- Reset mid-operation: rst at the 4th RUN cycle -> next cycle IDLE, in_ready=1, out_valid=0, diff=0; a subsequent a=0x10, b=0x01 yields diff=0x0F.
- WIDTH=1 instance: a=0, b=1 -> diff=1, borrow=1 two cycles after accept; a=1, b=1 -> diff=0, borrow=0.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the bit-serial arithmetic controllers.
package serial_arith_pkg;

    localparam int unsigned STATE_W = 2;

    typedef logic [STATE_W-1:0] state_bits_t;

    typedef enum state_bits_t {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bit counter width; never below one bit so WIDTH=1 still has a counter.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/sub_bit_cell.sv
// One-bit full subtractor: two half-subtractor stages, borrows ORed.
module sub_bit_cell (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bo
);

    logic hs1_d;
    logic hs1_b;
    logic hs2_b;

    always_comb begin
        hs1_d = x ^ y;
        hs1_b = ~x & y;
        d     = hs1_d ^ bin;
        hs2_b = ~hs1_d & bin;
        bo    = hs1_b | hs2_b;
    end

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial A-B controller, LSB first, valid/ready on both sides.
// Optional SERIAL_SUB_SAT_EN: clamp diff to 0 when the final borrow is set.
module serial_sub_ctrl
    import serial_arith_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);

    state_t             state_q,     state_d;
    logic [WIDTH-1:0]   a_sr_q,      a_sr_d;
    logic [WIDTH-1:0]   b_sr_q,      b_sr_d;
    logic [WIDTH-1:0]   diff_sr_q,   diff_sr_d;
    logic [WIDTH-1:0]   diff_q,      diff_d;
    logic               bor_q,       bor_d;
    logic               borrow_q,    borrow_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic               in_ready_q,  in_ready_d;
    logic               out_valid_q, out_valid_d;

    logic cell_d;
    logic cell_bo;

    sub_bit_cell u_cell (
        .x   (a_sr_q[0]),
        .y   (b_sr_q[0]),
        .bin (bor_q),
        .d   (cell_d),
        .bo  (cell_bo)
    );

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        a_sr_d    = a_sr_q;
        b_sr_d    = b_sr_q;
        diff_sr_d = diff_sr_q;
        diff_d    = diff_q;
        bor_d     = bor_q;
        borrow_d  = borrow_q;
        cnt_d     = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_sr_d    = a;
                    b_sr_d    = b;
                    diff_sr_d = '0;
                    bor_d     = 1'b0;
                    cnt_d     = '0;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                a_sr_d                = a_sr_q >> 1;
                b_sr_d                = b_sr_q >> 1;
                diff_sr_d             = diff_sr_q >> 1;
                diff_sr_d[WIDTH-1]    = cell_d;
                bor_d                 = cell_bo;
                cnt_d                 = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d  = ST_DONE;
                    borrow_d = cell_bo;
`ifdef SERIAL_SUB_SAT_EN
                    diff_d   = cell_bo ? '0 : diff_sr_d;
`else
                    diff_d   = diff_sr_d;
`endif
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Handshake flags track the registered state one-for-one
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            a_sr_q      <= '0;
            b_sr_q      <= '0;
            diff_sr_q   <= '0;
            diff_q      <= '0;
            bor_q       <= 1'b0;
            borrow_q    <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sr_q      <= a_sr_d;
            b_sr_q      <= b_sr_d;
            diff_sr_q   <= diff_sr_d;
            diff_q      <= diff_d;
            bor_q       <= bor_d;
            borrow_q    <= borrow_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign borrow    = borrow_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed bench for serial_sub_ctrl: WIDTH=8 and WIDTH=1 instances.
module tb_serial_sub_ctrl;

    logic       clk = 1'b0;
    logic       rst;

    logic       in_valid8, in_ready8, out_valid8, out_ready8, borrow8;
    logic [7:0] a8, b8, diff8;

    logic       in_valid1, in_ready1, out_valid1, out_ready1, borrow1;
    logic [0:0] a1, b1, diff1;

    int checks = 0;
    int errors = 0;
    int n;

    always #5 clk = ~clk;

    serial_sub_ctrl #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a8),
        .b         (b8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .diff      (diff8),
        .borrow    (borrow8)
    );

    serial_sub_ctrl #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .diff      (diff1),
        .borrow    (borrow1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after the accept edge; returns edges counted from accept to out_valid.
    task automatic wait_out8(output int cnt);
        cnt = 1;
        while (!out_valid8 && cnt < 40) begin
            tick();
            cnt++;
        end
    endtask

    // Present one operand pair to the 8-bit instance and check the result.
    task automatic op8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                       input logic [7:0] ed, input logic eb);
        int lat;
        in_valid8 = 1'b1;
        a8 = av;
        b8 = bv;
        tick();
        in_valid8 = 1'b0;
        wait_out8(lat);
        check({tag, "_lat"}, 32'(lat), 32'd9);
        check({tag, "_diff"}, 32'(diff8), 32'(ed));
        check({tag, "_borrow"}, 32'(borrow8), 32'(eb));
    endtask

    logic [7:0] exp_neg8;
    logic [0:0] exp_neg1;

    initial begin
`ifdef SERIAL_SUB_SAT_EN
        exp_neg8 = 8'h00;
        exp_neg1 = 1'b0;
`else
        exp_neg8 = 8'hFF;
        exp_neg1 = 1'b1;
`endif
        rst = 1'b1;
        in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0;
        in_valid1 = 1'b0; out_ready1 = 1'b1; a1 = '0; b1 = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_in_ready8",  32'(in_ready8),  32'd1);
        check("rst_out_valid8", 32'(out_valid8), 32'd0);
        check("rst_diff8",      32'(diff8),      32'd0);
        check("rst_borrow8",    32'(borrow8),    32'd0);
        check("rst_in_ready1",  32'(in_ready1),  32'd1);
        check("rst_out_valid1", 32'(out_valid1), 32'd0);

        // Basic subtract and wrap/borrow case
        op8("sub_5a_3c", 8'h5A, 8'h3C, 8'h1E, 1'b0);
        tick();
        check("idle_after_5a", 32'(in_ready8), 32'd1);
        op8("sub_00_01", 8'h00, 8'h01, exp_neg8, 1'b1);
        tick();

        // Backpressure: hold DONE with out_ready low
        out_ready8 = 1'b0;
        in_valid8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
        tick();
        in_valid8 = 1'b0;
        n = 1;
        while (!out_valid8 && n < 40) begin
            check("bp_run_in_ready", 32'(in_ready8), 32'd0);
            tick();
            n++;
        end
        check("bp_lat", 32'(n), 32'd9);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_out_valid", 32'(out_valid8), 32'd1);
            check("bp_diff",      32'(diff8),      32'h00);
            check("bp_borrow",    32'(borrow8),    32'd0);
            check("bp_in_ready",  32'(in_ready8),  32'd0);
        end
        out_ready8 = 1'b1;
        tick();
        check("bp_release_in_ready",  32'(in_ready8),  32'd1);
        check("bp_release_out_valid", 32'(out_valid8), 32'd0);

        // Operand stability: in_valid held with new operands during RUN
        in_valid8 = 1'b1; a8 = 8'h33; b8 = 8'h11;
        tick();
        a8 = 8'h01; b8 = 8'h02;
        wait_out8(n);
        check("stab_lat1",  32'(n),     32'd9);
        check("stab_diff1", 32'(diff8), 32'h22);
        check("stab_bor1",  32'(borrow8), 32'd0);
        tick();
        check("stab_idle_in_ready", 32'(in_ready8), 32'd1);
        tick();
        in_valid8 = 1'b0;
        wait_out8(n);
        check("stab_lat2",  32'(n),       32'd9);
        check("stab_diff2", 32'(diff8),   32'(exp_neg8));
        check("stab_bor2",  32'(borrow8), 32'd1);
        tick();

        // Reset in the 4th RUN cycle
        in_valid8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
        tick();
        in_valid8 = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_in_ready",  32'(in_ready8),  32'd1);
        check("mid_rst_out_valid", 32'(out_valid8), 32'd0);
        check("mid_rst_diff",      32'(diff8),      32'd0);
        op8("after_rst", 8'h10, 8'h01, 8'h0F, 1'b0);
        tick();

        // WIDTH=1 instance
        in_valid1 = 1'b1; a1 = 1'b0; b1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        n = 1;
        while (!out_valid1 && n < 10) begin
            tick();
            n++;
        end
        check("w1_lat_a",    32'(n),       32'd2);
        check("w1_diff_a",   32'(diff1),   32'(exp_neg1));
        check("w1_borrow_a", 32'(borrow1), 32'd1);
        tick();
        in_valid1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        n = 1;
        while (!out_valid1 && n < 10) begin
            tick();
            n++;
        end
        check("w1_lat_b",    32'(n),       32'd2);
        check("w1_diff_b",   32'(diff1),   32'd0);
        check("w1_borrow_b", 32'(borrow1), 32'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
